// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, multiply-sequencer states and default datapath width.
package alu_pkg;

    localparam int N_DEFAULT = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// EX-stage side and ALU side signals of the multiply sequencer.
import alu_pkg::*;

interface alu_mul_sequencer_if #(
    parameter int N = N_DEFAULT
);
    logic [2:0]   ex_ctrl;
    logic [N-1:0] ex_a;
    logic [N-1:0] ex_b;
    logic         mul_start;
    logic [N-1:0] alu_w;
    logic [2:0]   alu_ctrl;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic         stall;
    logic         mul_done;
    logic [N-1:0] mul_result;

    modport master (
        output ex_ctrl, ex_a, ex_b, mul_start, alu_w,
        input  alu_ctrl, alu_a, alu_b, stall, mul_done, mul_result
    );

    modport slave (
        input  ex_ctrl, ex_a, ex_b, mul_start, alu_w,
        output alu_ctrl, alu_a, alu_b, stall, mul_done, mul_result
    );
endinterface

// File: rtl/alu_port_mux.sv
// Selects what drives the ALU: the EX-stage request or the multiply sequencer's ADD.
import alu_pkg::*;

module alu_port_mux #(
    parameter int N = N_DEFAULT
) (
    input  logic         sel_seq,
    input  logic [2:0]   ex_ctrl,
    input  logic [N-1:0] ex_a,
    input  logic [N-1:0] ex_b,
    input  logic [N-1:0] seq_a,
    input  logic [N-1:0] seq_b,
    output logic [2:0]   alu_ctrl,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b
);
    always_comb begin
        if (sel_seq) begin
            alu_ctrl = ALU_ADD;
            alu_a    = seq_a;
            alu_b    = seq_b;
        end else begin
            alu_ctrl = ex_ctrl;
            alu_a    = ex_a;
            alu_b    = ex_b;
        end
    end
endmodule

// File: rtl/alu_mul_sequencer.sv
// Borrows the EX-stage ALU to run a shift-add 32-bit multiply (low product word).
//   state | meaning
//   IDLE  | ALU pass-through; mul_start latches operands
//   RUN   | one ADD per cycle, pipeline stalled
//   DONE  | mul_done pulse, mul_result valid
import alu_pkg::*;

module alu_mul_sequencer #(
    parameter int N     = N_DEFAULT,
    parameter int CNT_W = $clog2(N)
) (
    input  logic clk,
    input  logic rst,
    alu_mul_sequencer_if.slave bus
);
    seq_state_e       state_q, state_d;
    logic [N-1:0]     acc, mcand, mplier, mul_result_q;
    logic [CNT_W-1:0] cnt;
    logic             stall_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                stall_c = bus.mul_start;
                if (bus.mul_start) state_d = (bus.ex_b == '0) ? DONE : RUN;
            end
            RUN: begin
                stall_c = 1'b1;
                // Stop once no multiplier bits remain, or after the last bit position.
                if ((mplier >> 1) == '0 || cnt == CNT_W'(N - 1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            cnt          <= '0;
            mul_result_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.mul_start) begin
                    mcand  <= bus.ex_a;
                    mplier <= bus.ex_b;
                    acc    <= '0;
                    cnt    <= '0;
                    if (bus.ex_b == '0) mul_result_q <= '0;
                end
                RUN: begin
                    acc    <= bus.alu_w;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    // The final sum arrives on the ALU this cycle; capture it on the way into DONE.
                    if (state_d == DONE) mul_result_q <= bus.alu_w;
                end
                default: ;
            endcase
        end
    end

    assign bus.stall      = stall_c & ~rst;
    assign bus.mul_done   = (state_q == DONE);
    assign bus.mul_result = mul_result_q;

    alu_port_mux #(.N(N)) u_mux (
        .sel_seq  (state_q == RUN),
        .ex_ctrl  (bus.ex_ctrl),
        .ex_a     (bus.ex_a),
        .ex_b     (bus.ex_b),
        .seq_a    (acc),
        .seq_b    (mplier[0] ? mcand : '0),
        .alu_ctrl (bus.alu_ctrl),
        .alu_a    (bus.alu_a),
        .alu_b    (bus.alu_b)
    );
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural ALU closing the loop.
module tb_alu_mul_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_mul_sequencer_if #(.N(32)) bus();

    alu_mul_sequencer #(.N(32), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always_comb begin
        bus.alu_w = '0;
        case (bus.alu_ctrl)
            3'b000: bus.alu_w = bus.alu_a + bus.alu_b;
            3'b001: bus.alu_w = bus.alu_a - bus.alu_b;
            3'b010: bus.alu_w = bus.alu_a & bus.alu_b;
            3'b011: bus.alu_w = bus.alu_a | bus.alu_b;
            3'b100: bus.alu_w = bus.alu_a ^ bus.alu_b;
            3'b101: bus.alu_w = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
            default: bus.alu_w = '0;
        endcase
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
    } pt_vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] prod;
        int          lat;
    } mul_vec_t;

    task automatic pass_through(input string tag, input pt_vec_t v);
        @(negedge clk);
        bus.mul_start = 1'b0;
        bus.ex_ctrl   = v.ctrl;
        bus.ex_a      = v.a;
        bus.ex_b      = v.b;
        #1;
        chk({tag, " alu_ctrl"}, 32'(bus.alu_ctrl), 32'(v.ctrl));
        chk({tag, " alu_a"}, bus.alu_a, v.a);
        chk({tag, " alu_b"}, bus.alu_b, v.b);
        chk({tag, " stall"}, 32'(bus.stall), 32'd0);
    endtask

    task automatic run_mul(input string tag, input mul_vec_t v, input bit poke_mid);
        int cyc;
        bit seen;
        @(negedge clk);
        bus.ex_ctrl   = 3'b001;
        bus.ex_a      = v.a;
        bus.ex_b      = v.b;
        bus.mul_start = 1'b1;
        #1 chk({tag, " stall at start"}, 32'(bus.stall), 32'd1);
        @(posedge clk);
        #1;
        bus.mul_start = 1'b0;
        bus.ex_a      = 32'hdead_beef;
        bus.ex_b      = 32'h0f0f_0f0f;
        cyc  = 1;
        seen = 1'b0;
        while (cyc <= 40) begin
            @(negedge clk);
            if (bus.mul_done) begin
                seen = 1'b1;
                break;
            end
            if (cyc == 1) begin
                chk({tag, " run stall"}, 32'(bus.stall), 32'd1);
                chk({tag, " run alu_ctrl"}, 32'(bus.alu_ctrl), 32'(ALU_ADD));
                chk({tag, " run alu_a"}, bus.alu_a, 32'd0);
                chk({tag, " run alu_b"}, bus.alu_b, v.b[0] ? v.a : 32'd0);
            end
            if (poke_mid && cyc == 1) begin
                bus.mul_start = 1'b1;
                bus.ex_b      = 32'd3;
            end
            if (poke_mid && cyc == 2) bus.mul_start = 1'b0;
            @(posedge clk);
            cyc++;
        end
        if (!seen) begin
            total++;
            $display("FAIL %s timeout: no mul_done within 40 cycles", tag);
            return;
        end
        chk({tag, " latency"}, 32'(cyc), 32'(v.lat));
        chk({tag, " result"}, bus.mul_result, v.prod);
        chk({tag, " done stall"}, 32'(bus.stall), 32'd0);
        @(negedge clk);
        chk({tag, " done pulse width"}, 32'(bus.mul_done), 32'd0);
        chk({tag, " result held"}, bus.mul_result, v.prod);
    endtask

    pt_vec_t  pt_tab [4];
    mul_vec_t mul_tab[6];

    initial begin
        int ncyc;
        int dones;

        pt_tab[0] = '{3'b001, 32'd10, 32'd3};
        pt_tab[1] = '{3'b000, 32'hffff_ffff, 32'h0000_0001};
        pt_tab[2] = '{3'b101, 32'h8000_0000, 32'h7fff_ffff};
        pt_tab[3] = '{3'b100, 32'ha5a5_5a5a, 32'h1234_5678};

        mul_tab[0] = '{32'd3, 32'd5, 32'd15, 4};
        mul_tab[1] = '{32'h0000_1234, 32'd0, 32'd0, 1};
        mul_tab[2] = '{32'hffff_ffff, 32'hffff_ffff, 32'h0000_0001, 33};
        mul_tab[3] = '{32'd7, 32'd1, 32'd7, 2};
        mul_tab[4] = '{32'h0001_0000, 32'h0001_0000, 32'd0, 18};
        mul_tab[5] = '{32'd123, 32'h8000_0000, 32'h8000_0000, 33};

        bus.ex_ctrl   = 3'b000;
        bus.ex_a      = '0;
        bus.ex_b      = 32'd5;
        bus.mul_start = 1'b1;
        #2;
        chk("reset stall forced low", 32'(bus.stall), 32'd0);
        chk("reset mul_done", 32'(bus.mul_done), 32'd0);
        chk("reset mul_result", bus.mul_result, 32'd0);
        @(negedge clk);
        bus.mul_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) pass_through($sformatf("pt%0d", i), pt_tab[i]);
        for (int i = 0; i < 6; i++) run_mul($sformatf("mul%0d", i), mul_tab[i], 1'b0);

        run_mul("signed mid-start", '{32'hffff_fff9, 32'd6, 32'hffff_ffd6, 4}, 1'b1);

        // Abort a long multiply in RUN cycle 10; previous result 0xFFFFFFD6 must be cleared.
        @(negedge clk);
        bus.ex_ctrl   = 3'b001;
        bus.ex_a      = 32'd3;
        bus.ex_b      = 32'h8000_0000;
        bus.mul_start = 1'b1;
        @(posedge clk);
        #1 bus.mul_start = 1'b0;
        for (int i = 1; i < 10; i++) @(posedge clk);
        @(negedge clk);
        chk("abort in run stall", 32'(bus.stall), 32'd1);
        bus.ex_ctrl   = 3'b011;
        bus.ex_a      = 32'h0000_00f0;
        bus.ex_b      = 32'h0000_000f;
        bus.mul_start = 1'b1;
        rst           = 1'b1;
        #1;
        chk("abort stall", 32'(bus.stall), 32'd0);
        chk("abort mul_done", 32'(bus.mul_done), 32'd0);
        chk("abort mul_result", bus.mul_result, 32'd0);
        chk("abort alu_ctrl pass", 32'(bus.alu_ctrl), 32'd3);
        chk("abort alu_a pass", bus.alu_a, 32'h0000_00f0);
        @(negedge clk);
        bus.mul_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (ncyc = 0; ncyc < 35; ncyc++) begin
            @(negedge clk);
            if (bus.mul_done) dones++;
        end
        chk("abort no late done", 32'(dones), 32'd0);
        pass_through("post-reset pt", '{3'b010, 32'hf0f0_f0f0, 32'h0ff0_0ff0});
        run_mul("post-reset mul", '{32'd9, 32'd9, 32'd81, 5}, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: bench did not finish");
        $fatal(1);
    end
endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
Controller that owns the single EX-stage ALU and sequences it to execute a multi-cycle 32-bit multiply (MUL, low word of product) using the ALU ADD operation, shift-add style.
- When idle, it passes the pipeline's ALU request straight through to the ALU.
- When a multiply is issued, it takes the ALU over, stalls the pipeline, iterates, then returns the product with a one-cycle done pulse.
- It sits between EX-stage operand/control muxing and the ALU instance.

Parameters:
N, 32, datapath width; must match the ALU width.
CNT_W, 5, iteration counter width, equal to clog2(N).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
ex_ctrl  input  3  ALU operation requested by the EX stage.
ex_a  input  N  EX-stage operand A; multiplicand when mul_start.
ex_b  input  N  EX-stage operand B; multiplier when mul_start.
mul_start  input  1  EX stage holds a MUL; sampled only in IDLE.
alu_w  input  N  ALU result.
alu_ctrl  output  3  operation code driven to the ALU.
alu_a  output  N  ALU operand A.
alu_b  output  N  ALU operand B.
stall  output  1  freeze IF/ID/EX; combinational.
mul_done  output  1  one-cycle pulse; mul_result is valid.
mul_result  output  N  product low word; registered, held until the next start.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; acc, mcand, mplier and cnt are 0.
  - mul_result=0, mul_done=0.
  - stall is forced 0 while rst=1.
  - Reset in RUN aborts the multiply: no mul_done, mul_result is cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - alu_ctrl/alu_a/alu_b = ex_ctrl/ex_a/ex_b, combinational pass-through.
  - stall = mul_start.
  - On clk with mul_start=1: mcand<=ex_a, mplier<=ex_b, acc<=0, cnt<=0.
  - If ex_b==0, go to DONE; otherwise go to RUN.
- RUN:
  - stall=1; ex_* are ignored.
  - ALU is driven with alu_ctrl=ADD (3'b000), alu_a=acc, alu_b = mplier[0] ? mcand : 0.
  - Each clk: acc<=alu_w (wraps mod 2^N), mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
  - Leave for DONE when (mplier>>1)==0 or cnt==N-1 (early termination).
  - Number of RUN cycles = index of the highest set bit of ex_b, plus 1 (1..N).
- DONE:
  - mul_result<=acc at DONE entry, i.e. the register loads on the transition into DONE.
  - mul_done=1 for exactly this one cycle; stall=0.
  - ALU is back on pass-through.
  - Unconditionally go to IDLE next clk.
  - mul_start in DONE is ignored; the pipeline has advanced past the MUL.
- Latency from the mul_start cycle to the mul_done cycle = RUN cycles + 1, between 1 and N+1.
- Signedness: the low N bits of the product are identical for signed and unsigned operands, so no sign handling is needed.
- mul_start while in RUN or DONE: ignored, no re-latch.
- Operand values are captured at start. Later changes on ex_a/ex_b during RUN have no effect.

Decomposition:
- Shared package alu_pkg holds:
  - ALU opcodes ADD=000, SUB=001, AND=010, OR=011, XOR=100, SLT=101;
  - the state enum IDLE/RUN/DONE;
  - the N default.
- The ALU itself is not instantiated here; it is connected at EX-stage top level.
- One sub-module is natural: alu_port_mux, which selects pass-through or the sequencer drive.

Test Plan:
- Pass-through: IDLE, mul_start=0, ex_ctrl=SUB, ex_a=10, ex_b=3 -> alu_ctrl=001, alu_a=10, alu_b=3, stall=0 in the same cycle.
- MUL 3*5: start with ex_a=3, ex_b=5 -> stall high the start cycle plus 3 RUN cycles; mul_done on cycle 4 after start; mul_result=15.
- Zero multiplier: ex_a=0x1234, ex_b=0 -> DONE the next cycle; mul_done at latency 1; mul_result=0; no ADD issued.
- Full length: 0xFFFFFFFF*0xFFFFFFFF -> 32 RUN cycles, latency 33, mul_result=0x00000001.
- Signed: ex_a=-7 (0xFFFFFFF9), ex_b=6 -> 3 RUN cycles, mul_result=0xFFFFFFD6; a second mul_start pulsed mid-RUN is ignored.
- Reset mid-op: start 3*0x80000000, assert rst in RUN cycle 10 -> immediately state IDLE, stall=0, mul_result=0, no mul_done; after release, pass-through is functional.
